// File: rtl/systolic_mac_serdes_if.sv
// ---------------------------------------------------------------------------
// systolic_mac_serdes_if
// Bundles the beat-serial row/column streams of one systolic MAC cell.
//   row_in / col_in            : incoming data beats (DATA_W bits each)
//   row_ctrl_in / col_ctrl_in  : incoming control beats
//   sync                       : marks the current cycle as beat 0 of a new word
//   row_out / col_out          : outgoing data beats
//   row_ctrl_out / col_ctrl_out: outgoing control beats
//   frame_out                  : high while outgoing beat 0 is presented
// The master modport drives the inputs of the cell; the slave modport is
// the cell itself.
// ---------------------------------------------------------------------------
interface systolic_mac_serdes_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] row_in;
  logic [DATA_W-1:0] col_in;
  logic              row_ctrl_in;
  logic              col_ctrl_in;
  logic              sync;
  logic [DATA_W-1:0] row_out;
  logic [DATA_W-1:0] col_out;
  logic              row_ctrl_out;
  logic              col_ctrl_out;
  logic              frame_out;

  modport master (
    output row_in, col_in, row_ctrl_in, col_ctrl_in, sync,
    input  row_out, col_out, row_ctrl_out, col_ctrl_out, frame_out
  );

  modport slave (
    input  row_in, col_in, row_ctrl_in, col_ctrl_in, sync,
    output row_out, col_out, row_ctrl_out, col_ctrl_out, frame_out
  );
endinterface

// File: rtl/systolic_mac_serdes.sv
// ---------------------------------------------------------------------------
// systolic_mac_serdes
// One cell of a beat-serial systolic array. Row and column streams arrive
// MSB-first, BEATS beats per word. Each word is deserialised, optionally
// multiplied into a local accumulator, and re-serialised downstream with a
// fixed latency of one word. A flush request on the row control stream
// replaces the outgoing row word with the accumulator value.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : systolic_mac_serdes_if.slave (stream inputs/outputs, sync, frame)
// Parameters:
//   DATA_W : bits per beat
//   BEATS  : beats per word (>= 2)
//   SAT    : 1 = accumulator saturates at all-ones, 0 = wraps
// ---------------------------------------------------------------------------
module systolic_mac_serdes #(
  parameter int DATA_W = 4,
  parameter int BEATS  = 4,
  parameter int SAT    = 1
) (
  input logic                  clk,
  input logic                  rst,
  systolic_mac_serdes_if.slave bus
);

  localparam int W  = DATA_W * BEATS;
  localparam int BW = W - DATA_W;
  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  // registered state
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     rowBuf_q, rowBuf_d;
  logic [BW-1:0]     colBuf_q, colBuf_d;
  logic [BEATS-2:0]  rowCtrlBuf_q, rowCtrlBuf_d;
  logic [BEATS-2:0]  colCtrlBuf_q, colCtrlBuf_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [W-1:0]      obufRow_q, obufRow_d;
  logic [W-1:0]      obufCol_q, obufCol_d;
  logic [BEATS-1:0]  obufRowCtrl_q, obufRowCtrl_d;
  logic [BEATS-1:0]  obufColCtrl_q, obufColCtrl_d;
  logic [DATA_W-1:0] rowOut_q, rowOut_d;
  logic [DATA_W-1:0] colOut_q, colOut_d;
  logic              rowCtrlOut_q, rowCtrlOut_d;
  logic              colCtrlOut_q, colCtrlOut_d;
  logic              frame_q, frame_d;

  // combinational datapath
  logic [CW-1:0]    effCnt;
  logic             boundary;
  logic             dropOut;
  logic [W-1:0]     rowWord;
  logic [W-1:0]     colWord;
  logic [BEATS-1:0] rowCtrlWord;
  logic [BEATS-1:0] colCtrlWord;
  logic             accEn;
  logic             flush;
  logic [2*W-1:0]   product;
  logic [2*W:0]     sum;
  logic [W-1:0]     accNext;
  logic [W-1:0]     rowOutWord;
  logic [BEATS-1:0] rowOutCtrl;

  // Word assembly and multiply-accumulate. A sync pulse forces the current
  // beat to be treated as beat 0, which also suppresses any boundary that
  // would otherwise fall on this cycle.
  always_comb begin
    effCnt      = bus.sync ? '0 : cnt_q;
    boundary    = (effCnt == LAST);
    dropOut     = bus.sync && (cnt_q != '0);
    rowWord     = {rowBuf_q, bus.row_in};
    colWord     = {colBuf_q, bus.col_in};
    rowCtrlWord = {rowCtrlBuf_q, bus.row_ctrl_in};
    colCtrlWord = {colCtrlBuf_q, bus.col_ctrl_in};
    accEn       = colCtrlWord[BEATS-1];
    flush       = rowCtrlWord[BEATS-1];
    product     = (2*W)'(rowWord) * (2*W)'(colWord);
    sum         = (2*W+1)'(acc_q) + (2*W+1)'(product);
    if (!accEn) begin
      accNext = acc_q;
    end else if ((SAT != 0) && (sum[2*W:W] != '0)) begin
      accNext = '1;
    end else begin
      accNext = sum[W-1:0];
    end
    rowOutWord = flush ? accNext : rowWord;
    rowOutCtrl = rowCtrlWord;
    if (flush) begin
      // the flush request is consumed here and not forwarded downstream
      rowOutCtrl[BEATS-1] = 1'b0;
    end
  end

  // Next-state for the counter, input buffers, accumulator and serialiser.
  // The input buffers only ever hold beats 0..BEATS-2; the last beat is
  // taken straight from the ports at the boundary.
  always_comb begin
    cnt_d         = boundary ? '0 : effCnt + CW'(1);
    rowBuf_d      = rowBuf_q;
    colBuf_d      = colBuf_q;
    rowCtrlBuf_d  = rowCtrlBuf_q;
    colCtrlBuf_d  = colCtrlBuf_q;
    acc_d         = acc_q;
    obufRow_d     = obufRow_q;
    obufCol_d     = obufCol_q;
    obufRowCtrl_d = obufRowCtrl_q;
    obufColCtrl_d = obufColCtrl_q;
    rowOut_d      = rowOut_q;
    colOut_d      = colOut_q;
    rowCtrlOut_d  = rowCtrlOut_q;
    colCtrlOut_d  = colCtrlOut_q;
    frame_d       = 1'b0;

    for (int k = 0; k < BEATS - 1; k++) begin
      if (effCnt == CW'(k)) begin
        rowBuf_d[BW-1-k*DATA_W -: DATA_W] = bus.row_in;
        colBuf_d[BW-1-k*DATA_W -: DATA_W] = bus.col_in;
        rowCtrlBuf_d[BEATS-2-k]           = bus.row_ctrl_in;
        colCtrlBuf_d[BEATS-2-k]           = bus.col_ctrl_in;
      end
    end

    if (dropOut) begin
      // realignment: the word currently leaving the cell is replaced by zeros
      obufRow_d     = '0;
      obufCol_d     = '0;
      obufRowCtrl_d = '0;
      obufColCtrl_d = '0;
      rowOut_d      = '0;
      colOut_d      = '0;
      rowCtrlOut_d  = 1'b0;
      colCtrlOut_d  = 1'b0;
    end else if (boundary) begin
      acc_d         = flush ? '0 : accNext;
      obufRow_d     = rowOutWord;
      obufCol_d     = colWord;
      obufRowCtrl_d = rowOutCtrl;
      obufColCtrl_d = colCtrlWord;
      rowOut_d      = rowOutWord[W-1 -: DATA_W];
      colOut_d      = colWord[W-1 -: DATA_W];
      rowCtrlOut_d  = rowOutCtrl[BEATS-1];
      colCtrlOut_d  = colCtrlWord[BEATS-1];
      frame_d       = 1'b1;
    end else begin
      // present the beat following the one currently on the outputs
      for (int k = 1; k < BEATS; k++) begin
        if (cnt_q == CW'(k - 1)) begin
          rowOut_d     = obufRow_q[W-1-k*DATA_W -: DATA_W];
          colOut_d     = obufCol_q[W-1-k*DATA_W -: DATA_W];
          rowCtrlOut_d = obufRowCtrl_q[BEATS-1-k];
          colCtrlOut_d = obufColCtrl_q[BEATS-1-k];
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      rowBuf_q      <= '0;
      colBuf_q      <= '0;
      rowCtrlBuf_q  <= '0;
      colCtrlBuf_q  <= '0;
      acc_q         <= '0;
      obufRow_q     <= '0;
      obufCol_q     <= '0;
      obufRowCtrl_q <= '0;
      obufColCtrl_q <= '0;
      rowOut_q      <= '0;
      colOut_q      <= '0;
      rowCtrlOut_q  <= 1'b0;
      colCtrlOut_q  <= 1'b0;
      frame_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rowBuf_q      <= rowBuf_d;
      colBuf_q      <= colBuf_d;
      rowCtrlBuf_q  <= rowCtrlBuf_d;
      colCtrlBuf_q  <= colCtrlBuf_d;
      acc_q         <= acc_d;
      obufRow_q     <= obufRow_d;
      obufCol_q     <= obufCol_d;
      obufRowCtrl_q <= obufRowCtrl_d;
      obufColCtrl_q <= obufColCtrl_d;
      rowOut_q      <= rowOut_d;
      colOut_q      <= colOut_d;
      rowCtrlOut_q  <= rowCtrlOut_d;
      colCtrlOut_q  <= colCtrlOut_d;
      frame_q       <= frame_d;
    end
  end

  assign bus.row_out      = rowOut_q;
  assign bus.col_out      = colOut_q;
  assign bus.row_ctrl_out = rowCtrlOut_q;
  assign bus.col_ctrl_out = colCtrlOut_q;
  assign bus.frame_out    = frame_q;

endmodule

// File: tb/tb_systolic_mac_serdes.sv
// ---------------------------------------------------------------------------
// tb_systolic_mac_serdes
// Directed bench for systolic_mac_serdes (DATA_W=4, BEATS=4). Two cells are
// driven with the same streams: one saturating, one wrapping. Inputs change
// on the falling edge; outputs are logged per cycle on the falling edge and
// compared against hand-computed words afterwards.
// ---------------------------------------------------------------------------
module tb_systolic_mac_serdes;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  systolic_mac_serdes_if #(.DATA_W(4)) busSat ();
  systolic_mac_serdes_if #(.DATA_W(4)) busWrap ();

  systolic_mac_serdes #(.DATA_W(4), .BEATS(4), .SAT(1)) dutSat (
    .clk(clk),
    .rst(rst),
    .bus(busSat.slave)
  );

  systolic_mac_serdes #(.DATA_W(4), .BEATS(4), .SAT(0)) dutWrap (
    .clk(clk),
    .rst(rst),
    .bus(busWrap.slave)
  );

  // the wrapping cell sees exactly the same input streams
  assign busWrap.row_in      = busSat.row_in;
  assign busWrap.col_in      = busSat.col_in;
  assign busWrap.row_ctrl_in = busSat.row_ctrl_in;
  assign busWrap.col_ctrl_in = busSat.col_ctrl_in;
  assign busWrap.sync        = busSat.sync;

  // per-cycle output log
  logic [3:0] logRow     [0:127];
  logic [3:0] logCol     [0:127];
  logic       logRc      [0:127];
  logic       logCc      [0:127];
  logic       logFrame   [0:127];
  logic [3:0] logRowWrap [0:127];

  int cyc    = 0;
  int checks = 0;
  int passes = 0;

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Log this cycle's outputs, then drive the beat captured at the next rising edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] c,
                               input logic rc, input logic cc,
                               input logic sy, input logic rs);
    @(negedge clk);
    logRow[cyc]     = busSat.row_out;
    logCol[cyc]     = busSat.col_out;
    logRc[cyc]      = busSat.row_ctrl_out;
    logCc[cyc]      = busSat.col_ctrl_out;
    logFrame[cyc]   = busSat.frame_out;
    logRowWrap[cyc] = busWrap.row_out;
    busSat.row_in      = r;
    busSat.col_in      = c;
    busSat.row_ctrl_in = rc;
    busSat.col_ctrl_in = cc;
    busSat.sync        = sy;
    rst                = rs;
    cyc++;
  endtask

  // Send one whole word MSB-first, optionally with sync on its first beat.
  task automatic applyWord(input logic [15:0] r, input logic [15:0] c,
                           input logic [3:0] rc, input logic [3:0] cc,
                           input logic syncFirst);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(r[15-4*k -: 4], c[15-4*k -: 4], rc[3-k], cc[3-k],
                    (k == 0) && syncFirst, 1'b0);
    end
  endtask

  function automatic logic [15:0] rowWordAt(input int s);
    return {logRow[s], logRow[s+1], logRow[s+2], logRow[s+3]};
  endfunction

  function automatic logic [15:0] colWordAt(input int s);
    return {logCol[s], logCol[s+1], logCol[s+2], logCol[s+3]};
  endfunction

  function automatic logic [15:0] rowWrapWordAt(input int s);
    return {logRowWrap[s], logRowWrap[s+1], logRowWrap[s+2], logRowWrap[s+3]};
  endfunction

  function automatic logic [3:0] rcAt(input int s);
    return {logRc[s], logRc[s+1], logRc[s+2], logRc[s+3]};
  endfunction

  function automatic logic [3:0] ccAt(input int s);
    return {logCc[s], logCc[s+1], logCc[s+2], logCc[s+3]};
  endfunction

  function automatic logic [3:0] frameAt(input int s);
    return {logFrame[s], logFrame[s+1], logFrame[s+2], logFrame[s+3]};
  endfunction

  function automatic logic [10:0] allOutAt(input int s);
    return {logRow[s], logCol[s], logRc[s], logCc[s], logFrame[s]};
  endfunction

  // Stimulus sequence followed by the checks on the logged outputs.
  initial begin
    rst                = 1'b1;
    busSat.row_in      = '0;
    busSat.col_in      = '0;
    busSat.row_ctrl_in = 1'b0;
    busSat.col_ctrl_in = 1'b0;
    busSat.sync        = 1'b0;

    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // words 0..10 start at cycle 2+4n and appear at cycle 6+4n
    applyWord(16'h1234, 16'hABCD, 4'h0, 4'h0, 1'b0);
    applyWord(16'h0003, 16'h0005, 4'h0, 4'h8, 1'b0);
    applyWord(16'h0002, 16'h0004, 4'h8, 4'h8, 1'b0);
    applyWord(16'h0055, 16'h0066, 4'h8, 4'h0, 1'b0);
    applyWord(16'hFFFF, 16'hFFFF, 4'h0, 4'h8, 1'b0);
    applyWord(16'hFFFF, 16'hFFFF, 4'h0, 4'h8, 1'b0);
    applyWord(16'h0000, 16'h0000, 4'h8, 4'h0, 1'b0);
    applyWord(16'h0001, 16'h0003, 4'h0, 4'h8, 1'b0);
    applyWord(16'h0001, 16'h0007, 4'hB, 4'h8, 1'b0);
    applyWord(16'h0000, 16'h0000, 4'h8, 4'h0, 1'b0);
    applyWord(16'h0002, 16'h0008, 4'h0, 4'h8, 1'b0);

    // partial word at cycles 46,47 then sync at cycle 48 (cnt==2)
    applyStimulus(4'h9, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h9, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
    applyWord(16'h1357, 16'h2468, 4'h0, 4'h0, 1'b1);
    applyWord(16'h0000, 16'h0000, 4'h8, 4'h0, 1'b0);

    // acc := 0x10, then reset at cycle 62 (cnt==2)
    applyWord(16'h0004, 16'h0004, 4'h0, 4'h8, 1'b0);
    applyStimulus(4'h5, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h5, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h5, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
    applyWord(16'h0000, 16'h0000, 4'h8, 4'h0, 1'b0);

    while (cyc < 75) begin
      applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    checkOutput("reset_state",    32'(allOutAt(2)),       32'h0);
    checkOutput("pre_boundary",   32'(allOutAt(5)),       32'h0);
    checkOutput("pass_row",       32'(rowWordAt(6)),      32'h1234);
    checkOutput("pass_col",       32'(colWordAt(6)),      32'hABCD);
    checkOutput("pass_frame",     32'(frameAt(6)),        32'h8);
    checkOutput("pass_ctrl",      32'({rcAt(6), ccAt(6)}), 32'h0);
    checkOutput("acc_row",        32'(rowWordAt(10)),     32'h0003);
    checkOutput("acc_colctrl",    32'(ccAt(10)),          32'h8);
    checkOutput("flush_row",      32'(rowWordAt(14)),     32'h0017);
    checkOutput("flush_rowctrl",  32'(rcAt(14)),          32'h0);
    checkOutput("flush_col",      32'({colWordAt(14), ccAt(14)}), 32'h00048);
    checkOutput("flush_empty",    32'(rowWordAt(18)),     32'h0000);
    checkOutput("sat_passrow",    32'(rowWordAt(22)),     32'hFFFF);
    checkOutput("sat_flush",      32'(rowWordAt(30)),     32'hFFFF);
    checkOutput("wrap_flush",     32'(rowWrapWordAt(30)), 32'h0002);
    checkOutput("accflush_row",   32'(rowWordAt(38)),     32'h000A);
    checkOutput("accflush_ctrl",  32'(rcAt(38)),          32'h3);
    checkOutput("accflush_clear", 32'(rowWordAt(42)),     32'h0000);
    checkOutput("sync_drop",      32'(allOutAt(49)),      32'h0);
    checkOutput("sync_row",       32'(rowWordAt(52)),     32'h1357);
    checkOutput("sync_col",       32'(colWordAt(52)),     32'h2468);
    checkOutput("sync_frame",     32'(frameAt(52)),       32'h8);
    checkOutput("sync_acc_kept",  32'(rowWordAt(56)),     32'h0010);
    checkOutput("midrst_outputs", 32'(allOutAt(63)),      32'h0);
    checkOutput("midrst_acc",     32'(rowWordAt(67)),     32'h0000);
    checkOutput("midrst_frame",   32'(frameAt(67)),       32'h8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
